// File: rtl/ahblite_slave_mux.sv
// ahblite_slave_mux
//   Response-side partner of the AHB-Lite address decoder. At each address
//   phase (HREADY=1) it registers which slave port the decoder picked. During
//   the data phase it routes that port's HREADYOUT/HRDATA/HRESP back to the
//   master. Transfers that hit no enabled port go to a built-in default slave.
//   That slave answers IDLE/BUSY with a zero-wait OKAY and answers NONSEQ/SEQ
//   with a two-cycle ERROR.
//
// Ports
//   HCLK, HRESET            clock, synchronous active-high reset
//   HTRANS[1:0]             master transfer type (bit 1 = active transfer)
//   Pk_HSEL                 decoder select for port k (address phase)
//   Pk_HREADYOUT/HRDATA/HRESP  slave k response (data phase)
//   HREADY, HRDATA, HRESP   muxed response to the master (HREADY also to slaves)
module ahblite_slave_mux #(
    parameter logic Port0_en = 1'b1,
    parameter logic Port1_en = 1'b1,
    parameter logic Port2_en = 1'b1,
    parameter logic Port3_en = 1'b1,
    parameter logic Port4_en = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [1:0]  HTRANS,
    input  logic        P0_HSEL,
    input  logic        P1_HSEL,
    input  logic        P2_HSEL,
    input  logic        P3_HSEL,
    input  logic        P4_HSEL,
    input  logic        P0_HREADYOUT,
    input  logic        P1_HREADYOUT,
    input  logic        P2_HREADYOUT,
    input  logic        P3_HREADYOUT,
    input  logic        P4_HREADYOUT,
    input  logic [31:0] P0_HRDATA,
    input  logic [31:0] P1_HRDATA,
    input  logic [31:0] P2_HRDATA,
    input  logic [31:0] P3_HRDATA,
    input  logic [31:0] P4_HRDATA,
    input  logic        P0_HRESP,
    input  logic        P1_HRESP,
    input  logic        P2_HRESP,
    input  logic        P3_HRESP,
    input  logic        P4_HRESP,
    output logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HRESP
);

    localparam int NUM_PORTS = 5;
    localparam logic [NUM_PORTS-1:0] PORT_EN =
        {Port4_en, Port3_en, Port2_en, Port1_en, Port0_en};

    typedef enum logic [1:0] {IDLE, ERR1, ERR2} def_state_t;

    logic [NUM_PORTS-1:0]       hsel;
    logic [NUM_PORTS-1:0]       hreadyout;
    logic [NUM_PORTS-1:0]       hresp_in;
    logic [NUM_PORTS-1:0][31:0] hrdata_in;

    assign hsel      = {P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL};
    assign hreadyout = {P4_HREADYOUT, P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
    assign hresp_in  = {P4_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};
    assign hrdata_in = {P4_HRDATA, P3_HRDATA, P2_HRDATA, P1_HRDATA, P0_HRDATA};

    // Only the active/inactive distinction of HTRANS matters here.
    logic unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    // Address-phase select: mask disabled ports and keep only the lowest set
    // bit. x & -x isolates that bit, so sel_d is one-hot or zero.
    logic [NUM_PORTS-1:0] en_sel;
    logic [NUM_PORTS-1:0] sel_d;
    logic                 def_d;

    assign en_sel = hsel & PORT_EN;
    assign sel_d  = en_sel & (~en_sel + 5'd1);
    assign def_d  = (sel_d == '0);

    // Data-phase state
    logic [NUM_PORTS-1:0] sel_q;
    logic                 def_q;
    def_state_t           state, state_nxt;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q <= '0;
            def_q <= 1'b1;
            state <= IDLE;
        end else begin
            state <= state_nxt;
            if (HREADY) begin
                sel_q <= sel_d;
                def_q <= def_d;
            end
        end
    end

    // Default slave. It advances on the muxed HREADY, not only while def_q=1.
    // This lets an unmapped NONSEQ issued during a mapped slave's final data
    // cycle land directly in ERR1.
    logic def_ready, def_resp;

    always_comb begin
        state_nxt = state;
        def_ready = 1'b1;
        def_resp  = 1'b0;
        case (state)
            IDLE: begin
                if (HREADY && def_d && HTRANS[1]) state_nxt = ERR1;
            end
            ERR1: begin
                def_ready = 1'b0;
                def_resp  = 1'b1;
                state_nxt = ERR2;
            end
            ERR2: begin
                def_resp  = 1'b1;
                // ERR2 is itself an address phase (HREADY=1).
                state_nxt = (def_d && HTRANS[1]) ? ERR1 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slave response mux. sel_q is one-hot, so AND-OR is enough.
    logic        slv_ready, slv_resp;
    logic [31:0] slv_rdata;

    always_comb begin
        slv_ready = 1'b0;
        slv_resp  = 1'b0;
        slv_rdata = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            slv_ready = slv_ready | (sel_q[k] & hreadyout[k]);
            slv_resp  = slv_resp  | (sel_q[k] & hresp_in[k]);
            slv_rdata = slv_rdata | ({32{sel_q[k]}} & hrdata_in[k]);
        end
    end

    assign HREADY = def_q ? def_ready : slv_ready;
    assign HRESP  = def_q ? def_resp  : slv_resp;
    assign HRDATA = def_q ? 32'h0     : slv_rdata;

endmodule

// File: tb/tb_ahblite_slave_mux.sv
module tb_ahblite_slave_mux;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [1:0]  HTRANS;
    logic [4:0]  hsel;
    logic [4:0]  hrdy;
    logic [4:0]  hrsp;
    logic [31:0] hrd [5];

    logic        HREADY, HRESP;
    logic [31:0] HRDATA;
    logic        d_HREADY, d_HRESP;
    logic [31:0] d_HRDATA;

    int n_tot = 0;
    int n_bad = 0;

    always #5 HCLK = ~HCLK;

    // All ports enabled
    ahblite_slave_mux u_main (
        .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS),
        .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]),
        .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]),
        .P0_HREADYOUT(hrdy[0]), .P1_HREADYOUT(hrdy[1]), .P2_HREADYOUT(hrdy[2]),
        .P3_HREADYOUT(hrdy[3]), .P4_HREADYOUT(hrdy[4]),
        .P0_HRDATA(hrd[0]), .P1_HRDATA(hrd[1]), .P2_HRDATA(hrd[2]),
        .P3_HRDATA(hrd[3]), .P4_HRDATA(hrd[4]),
        .P0_HRESP(hrsp[0]), .P1_HRESP(hrsp[1]), .P2_HRESP(hrsp[2]),
        .P3_HRESP(hrsp[3]), .P4_HRESP(hrsp[4]),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    // Port 4 disabled, same stimulus
    ahblite_slave_mux #(.Port4_en(1'b0)) u_dis (
        .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS),
        .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]),
        .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]),
        .P0_HREADYOUT(hrdy[0]), .P1_HREADYOUT(hrdy[1]), .P2_HREADYOUT(hrdy[2]),
        .P3_HREADYOUT(hrdy[3]), .P4_HREADYOUT(hrdy[4]),
        .P0_HRDATA(hrd[0]), .P1_HRDATA(hrd[1]), .P2_HRDATA(hrd[2]),
        .P3_HRDATA(hrd[3]), .P4_HRDATA(hrd[4]),
        .P0_HRESP(hrsp[0]), .P1_HRESP(hrsp[1]), .P2_HRESP(hrsp[2]),
        .P3_HRESP(hrsp[3]), .P4_HRESP(hrsp[4]),
        .HREADY(d_HREADY), .HRDATA(d_HRDATA), .HRESP(d_HRESP)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock. Inputs change 1 ns after the edge; checks run 2 ns later.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic bus_idle();
        hsel   = '0;
        HTRANS = 2'b00;
    endtask

    logic [31:0] pat [5];
    int          order [5];

    initial begin
        pat[0] = 32'h0000_A0A0; pat[1] = 32'hDEAD_BEEF; pat[2] = 32'h2222_C0DE;
        pat[3] = 32'h3333_F00D; pat[4] = 32'h4444_CAFE;
        order[0] = 1; order[1] = 0; order[2] = 2; order[3] = 3; order[4] = 4;

        HRESET = 1'b1;
        bus_idle();
        hrdy = '1;
        hrsp = '0;
        for (int k = 0; k < 5; k++) hrd[k] = pat[k];

        // Reset held for two cycles
        tick(); tick();
        HRESET = 1'b0;
        settle();
        chk("rst_hready", {31'd0, HREADY}, 32'd1);
        chk("rst_hresp",  {31'd0, HRESP},  32'd0);
        chk("rst_hrdata", HRDATA, 32'h0);

        // Routing to each port (port 1 first)
        for (int i = 0; i < 5; i++) begin
            hsel = 5'b00001 << order[i];
            HTRANS = 2'b10;
            tick();
            bus_idle();
            settle();
            chk($sformatf("route%0d_data", order[i]), HRDATA, pat[order[i]]);
            chk($sformatf("route%0d_resp", order[i]), {31'd0, HRESP}, 32'd0);
            chk($sformatf("route%0d_rdy", order[i]), {31'd0, HREADY}, 32'd1);
        end

        // Priority: P1 and P3 both selected -> P1
        hsel = 5'b01010; HTRANS = 2'b10;
        tick();
        bus_idle(); settle();
        chk("prio_data", HRDATA, pat[1]);

        // Slave ERROR passthrough: first cycle HRESP=1 HREADY=0
        hsel = 5'b00100; HTRANS = 2'b10;
        tick();
        bus_idle();
        hrdy[2] = 1'b0; hrsp[2] = 1'b1;
        settle();
        chk("pass_resp", {31'd0, HRESP}, 32'd1);
        chk("pass_rdy",  {31'd0, HREADY}, 32'd0);
        tick();
        hrdy[2] = 1'b1; hrsp[2] = 1'b0;

        // Wait states on P3 while P0 is presented
        hsel = 5'b01000; HTRANS = 2'b10;
        tick();
        hsel = 5'b00001; HTRANS = 2'b10;
        hrdy[3] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("wait%0d_rdy", i), {31'd0, HREADY}, 32'd0);
            chk($sformatf("wait%0d_data", i), HRDATA, pat[3]);
            tick();
        end
        hrdy[3] = 1'b1;
        settle();
        chk("wait_end_rdy",  {31'd0, HREADY}, 32'd1);
        chk("wait_end_data", HRDATA, pat[3]);
        tick();
        bus_idle(); settle();
        chk("after_wait_p0", HRDATA, pat[0]);

        // Unmapped NONSEQ -> ERR1, ERR2
        HTRANS = 2'b10;
        tick();
        bus_idle(); settle();
        chk("err1_rdy",  {31'd0, HREADY}, 32'd0);
        chk("err1_resp", {31'd0, HRESP},  32'd1);
        chk("err1_data", HRDATA, 32'h0);
        tick(); settle();
        chk("err2_rdy",  {31'd0, HREADY}, 32'd1);
        chk("err2_resp", {31'd0, HRESP},  32'd1);
        chk("err2_data", HRDATA, 32'h0);
        // Unmapped IDLE -> zero-wait OKAY
        tick(); tick(); settle();
        chk("unm_idle_rdy",  {31'd0, HREADY}, 32'd1);
        chk("unm_idle_resp", {31'd0, HRESP},  32'd0);

        // Back-to-back unmapped NONSEQs, then P2 presented in the last ERR2
        HTRANS = 2'b10;
        tick(); settle();
        chk("b2b_e1a", {30'd0, HREADY, HRESP}, 32'b01);
        tick(); settle();
        chk("b2b_e2a", {30'd0, HREADY, HRESP}, 32'b11);
        tick();
        hsel = 5'b00100;
        settle();
        chk("b2b_e1b", {30'd0, HREADY, HRESP}, 32'b01);
        tick(); settle();
        chk("b2b_e2b", {30'd0, HREADY, HRESP}, 32'b11);
        tick();
        bus_idle(); settle();
        chk("b2b_p2_data", HRDATA, pat[2]);
        chk("b2b_p2_resp", {30'd0, HREADY, HRESP}, 32'b10);

        // Mapped followed directly by unmapped NONSEQ
        hsel = 5'b00010; HTRANS = 2'b10;
        tick();
        hsel = '0; HTRANS = 2'b10;
        settle();
        chk("m2u_p1_data", HRDATA, pat[1]);
        tick();
        bus_idle(); settle();
        chk("m2u_err1", {30'd0, HREADY, HRESP}, 32'b01);
        tick(); tick(); tick();

        // Disabled port 4: u_dis errors while u_main routes; reset during ERR1
        hsel = 5'b10000; HTRANS = 2'b10;
        tick();
        bus_idle(); settle();
        chk("dis_err1", {30'd0, d_HREADY, d_HRESP}, 32'b01);
        chk("dis_data", d_HRDATA, 32'h0);
        chk("en_p4_data", HRDATA, pat[4]);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        settle();
        chk("dis_rst", {30'd0, d_HREADY, d_HRESP}, 32'b10);
        chk("dis_rst_data", d_HRDATA, 32'h0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
